// File: rtl/arbitro_mux_if.sv
// Bundle of the request, output and debug-counter signals of arbitro_mux.
// A word moves on any edge where its valid and ready are both high; requesters hold valid/dato stable until ready.
interface arbitro_mux_if #(
  parameter int ANCHO     = 32,
  parameter int ANCHO_CNT = 16
);
  logic                 req0_valid;
  logic [ANCHO-1:0]     req0_dato;
  logic                 req0_ready;
  logic                 req1_valid;
  logic [ANCHO-1:0]     req1_dato;
  logic                 req1_ready;
  logic                 seleccionador;
  logic                 sal_valid;
  logic [ANCHO-1:0]     sal_dato;
  logic                 sal_fuente;
  logic                 sal_ready;
  logic [ANCHO_CNT-1:0] cuenta0;
  logic [ANCHO_CNT-1:0] cuenta1;

  modport slave (
    input  req0_valid, req0_dato, req1_valid, req1_dato, sal_ready,
    output req0_ready, req1_ready, seleccionador,
    output sal_valid, sal_dato, sal_fuente, cuenta0, cuenta1
  );

  modport master (
    output req0_valid, req0_dato, req1_valid, req1_dato, sal_ready,
    input  req0_ready, req1_ready, seleccionador,
    input  sal_valid, sal_dato, sal_fuente, cuenta0, cuenta1
  );
endinterface

// File: rtl/arbitro_mux.sv
// Two-source round-robin arbiter feeding a registered 2:1 datapath mux,
// with saturating per-source transfer counters.
module arbitro_mux #(
  parameter int ANCHO     = 32,
  parameter int ANCHO_CNT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  arbitro_mux_if.slave    bus,
  output logic            o_estado
);

  typedef enum logic {
    LIBRE   = 1'b0,
    OCUPADO = 1'b1
  } estado_t;

  localparam logic [ANCHO_CNT-1:0] CNT_UNO = {{(ANCHO_CNT-1){1'b0}}, 1'b1};
  localparam logic [ANCHO_CNT-1:0] CNT_MAX = {ANCHO_CNT{1'b1}};

  estado_t              r_estado;
  estado_t              w_estado_sig;
  logic [ANCHO-1:0]     r_dato;
  logic                 r_fuente;
  logic                 r_prioridad;
  logic [ANCHO_CNT-1:0] r_cuenta0;
  logic [ANCHO_CNT-1:0] r_cuenta1;

  logic                 w_carga;
  logic                 w_grant;
  logic                 w_ready0;
  logic                 w_ready1;
  logic                 w_xfer0;
  logic                 w_xfer1;
  logic                 w_xfer;
  logic [ANCHO-1:0]     w_dato_sel;

  // Grant: a lone requester wins; a tie or an idle cycle falls back to prioridad.
  always_comb begin
    w_grant = r_prioridad;
    if (bus.req0_valid && !bus.req1_valid) begin
      w_grant = 1'b0;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_carga    = (r_estado == LIBRE) | bus.sal_ready;
  assign w_ready0   = w_carga & bus.req0_valid & (w_grant == 1'b0);
  assign w_ready1   = w_carga & bus.req1_valid & (w_grant == 1'b1);
  assign w_xfer0    = bus.req0_valid & w_ready0;
  assign w_xfer1    = bus.req1_valid & w_ready1;
  assign w_xfer     = w_xfer0 | w_xfer1;
  assign w_dato_sel = w_grant ? bus.req1_dato : bus.req0_dato;

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      LIBRE: begin
        if (w_xfer) begin
          w_estado_sig = OCUPADO;
        end
      end
      OCUPADO: begin
        // A consume paired with a new transfer reloads without a bubble.
        if (w_xfer) begin
          w_estado_sig = OCUPADO;
        end else if (bus.sal_ready) begin
          w_estado_sig = LIBRE;
        end
      end
      default: w_estado_sig = LIBRE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= LIBRE;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dato      <= '0;
      r_fuente    <= 1'b0;
      r_prioridad <= 1'b0;
    end else if (w_xfer) begin
      r_dato      <= w_dato_sel;
      r_fuente    <= w_grant;
      r_prioridad <= ~w_grant;
    end
  end

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cuenta0 <= '0;
      r_cuenta1 <= '0;
    end else begin
      if (w_xfer0 && (r_cuenta0 != CNT_MAX)) begin
        r_cuenta0 <= r_cuenta0 + CNT_UNO;
      end
      if (w_xfer1 && (r_cuenta1 != CNT_MAX)) begin
        r_cuenta1 <= r_cuenta1 + CNT_UNO;
      end
    end
  end

  assign bus.req0_ready    = w_ready0;
  assign bus.req1_ready    = w_ready1;
  assign bus.seleccionador = w_grant;
  assign bus.sal_valid     = (r_estado == OCUPADO);
  assign bus.sal_dato      = r_dato;
  assign bus.sal_fuente    = r_fuente;
  assign bus.cuenta0       = r_cuenta0;
  assign bus.cuenta1       = r_cuenta1;
  assign o_estado          = r_estado;

endmodule

// File: tb/tb_arbitro_mux.sv
// Bench for arbitro_mux: directed vector table, randomized run against a
// rule-level model, reset-mid-transfer and counter-saturation sequences.
`timescale 1ns/1ps
module tb_arbitro_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic estado;
  logic estado_s;

  always #5 clk = ~clk;

  arbitro_mux_if #(.ANCHO(32), .ANCHO_CNT(16)) bus ();
  arbitro_mux_if #(.ANCHO(32), .ANCHO_CNT(4))  bus_s ();

  arbitro_mux #(.ANCHO(32), .ANCHO_CNT(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .o_estado(estado)
  );

  arbitro_mux #(.ANCHO(32), .ANCHO_CNT(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s), .o_estado(estado_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: output slot, its source, priority pointer, counters.
  logic        m_valid;
  logic [31:0] m_dato;
  logic        m_src;
  logic        m_prio;
  int          m_cnt[2];

  task automatic model_reset();
    m_valid = 1'b0; m_dato = '0; m_src = 1'b0; m_prio = 1'b0;
    m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  task automatic model_step(input logic v0, input logic [31:0] d0,
                            input logic v1, input logic [31:0] d1,
                            input logic rdy,
                            output logic er0, output logic er1, output logic esel);
    logic        v[2];
    logic [31:0] d[2];
    logic        puede;
    int          g;
    v[0] = v0; v[1] = v1; d[0] = d0; d[1] = d1;
    puede = !m_valid || rdy;
    if (v[0] && v[1]) g = int'(m_prio);
    else if (v[0])    g = 0;
    else if (v[1])    g = 1;
    else              g = int'(m_prio);
    esel = (g == 1);
    er0 = puede && v[0] && (g == 0);
    er1 = puede && v[1] && (g == 1);
    if (puede && v[g]) begin
      m_valid = 1'b1;
      m_dato  = d[g];
      m_src   = (g == 1);
      m_prio  = (g == 0);
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // Drives one cycle: inputs after the falling edge, combinational outputs
  // sampled before the rising edge, registers sampled just after it.
  task automatic step(input logic v0, input logic [31:0] d0,
                      input logic v1, input logic [31:0] d1,
                      input logic rdy,
                      output logic r0, output logic r1, output logic sel);
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_dato = d0;
    bus.req1_valid = v1; bus.req1_dato = d1;
    bus.sal_ready  = rdy;
    #1;
    r0 = bus.req0_ready; r1 = bus.req1_ready; sel = bus.seleccionador;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic v0; logic [31:0] d0; logic v1; logic [31:0] d1; logic rdy;
    logic r0; logic r1; logic sel; logic val; logic [31:0] dato; logic src;
    int c0; int c1;
  } vec_t;

  vec_t tabla[16];

  initial begin
    logic r0, r1, sel, er0, er1, esel;
    logic v0, v1, rdy;
    logic [31:0] d0, d1;

    bus.req0_valid = 0; bus.req0_dato = '0; bus.req1_valid = 0; bus.req1_dato = '0;
    bus.sal_ready = 0;
    bus_s.req0_valid = 0; bus_s.req0_dato = '0; bus_s.req1_valid = 0; bus_s.req1_dato = '0;
    bus_s.sal_ready = 0;

    //          v0 d0 v1 d1 rdy r0 r1 sel val dato src c0 c1
    tabla[0]  = '{1, 1, 0, 0, 1,  1, 0, 0,  1,  1,  0,  1, 0};
    tabla[1]  = '{1, 1, 1, 2, 1,  0, 1, 1,  1,  2,  1,  1, 1};
    tabla[2]  = '{1, 1, 1, 2, 1,  1, 0, 0,  1,  1,  0,  2, 1};
    tabla[3]  = '{1, 1, 1, 2, 1,  0, 1, 1,  1,  2,  1,  2, 2};
    tabla[4]  = '{1, 1, 1, 2, 1,  1, 0, 0,  1,  1,  0,  3, 2};
    tabla[5]  = '{1, 1, 1, 2, 1,  0, 1, 1,  1,  2,  1,  3, 3};
    tabla[6]  = '{1, 1, 1, 2, 0,  0, 0, 0,  1,  2,  1,  3, 3};
    tabla[7]  = '{1, 1, 1, 2, 0,  0, 0, 0,  1,  2,  1,  3, 3};
    tabla[8]  = '{1, 1, 1, 2, 0,  0, 0, 0,  1,  2,  1,  3, 3};
    tabla[9]  = '{1, 1, 1, 2, 1,  1, 0, 0,  1,  1,  0,  4, 3};
    tabla[10] = '{0, 0, 0, 0, 1,  0, 0, 1,  0,  1,  0,  4, 3};
    tabla[11] = '{0, 0, 0, 0, 0,  0, 0, 1,  0,  1,  0,  4, 3};
    tabla[12] = '{0, 0, 1, 5, 0,  0, 1, 1,  1,  5,  1,  4, 4};
    tabla[13] = '{1, 9, 0, 0, 0,  0, 0, 0,  1,  5,  1,  4, 4};
    tabla[14] = '{1, 9, 0, 0, 1,  1, 0, 0,  1,  9,  0,  5, 4};
    tabla[15] = '{0, 0, 0, 0, 1,  0, 0, 1,  0,  9,  0,  5, 4};

    // Clock/reset
    #1;
    chk("reset sal_valid", bus.sal_valid, 0);
    chk("reset sal_dato", bus.sal_dato, 0);
    chk("reset sal_fuente", bus.sal_fuente, 0);
    chk("reset cuenta0", bus.cuenta0, 0);
    chk("reset cuenta1", bus.cuenta1, 0);
    chk("reset estado", estado, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Directed vectors
    for (int i = 0; i < 16; i++) begin
      step(tabla[i].v0, tabla[i].d0, tabla[i].v1, tabla[i].d1, tabla[i].rdy, r0, r1, sel);
      model_step(tabla[i].v0, tabla[i].d0, tabla[i].v1, tabla[i].d1, tabla[i].rdy, er0, er1, esel);
      chk($sformatf("vec%0d req0_ready", i), r0, tabla[i].r0);
      chk($sformatf("vec%0d req1_ready", i), r1, tabla[i].r1);
      chk($sformatf("vec%0d seleccionador", i), sel, tabla[i].sel);
      chk($sformatf("vec%0d sal_valid", i), bus.sal_valid, tabla[i].val);
      chk($sformatf("vec%0d estado", i), estado, tabla[i].val);
      chk($sformatf("vec%0d sal_dato", i), bus.sal_dato, tabla[i].dato);
      chk($sformatf("vec%0d sal_fuente", i), bus.sal_fuente, tabla[i].src);
      chk($sformatf("vec%0d cuenta0", i), bus.cuenta0, tabla[i].c0);
      chk($sformatf("vec%0d cuenta1", i), bus.cuenta1, tabla[i].c1);
    end

    // Randomized traffic; requesters keep valid/dato until accepted
    v0 = 0; v1 = 0; d0 = '0; d1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!v0) begin v0 = ($urandom_range(0, 99) < 60); d0 = $urandom; end
      if (!v1) begin v1 = ($urandom_range(0, 99) < 60); d1 = $urandom; end
      rdy = ($urandom_range(0, 99) < 65);
      step(v0, d0, v1, d1, rdy, r0, r1, sel);
      model_step(v0, d0, v1, d1, rdy, er0, er1, esel);
      chk("rnd req0_ready", r0, er0);
      chk("rnd req1_ready", r1, er1);
      chk("rnd seleccionador", sel, esel);
      chk("rnd sal_valid", bus.sal_valid, m_valid);
      if (m_valid) begin
        chk("rnd sal_dato", bus.sal_dato, m_dato);
        chk("rnd sal_fuente", bus.sal_fuente, m_src);
      end
      chk("rnd cuenta0", bus.cuenta0, m_cnt[0]);
      chk("rnd cuenta1", bus.cuenta1, m_cnt[1]);
      if (r0) v0 = 0;
      if (r1) v1 = 0;
    end

    // Reset between edges while a word is held
    step(1, 7, 0, 0, 1, r0, r1, sel);
    chk("pre-reset sal_dato", bus.sal_dato, 7);
    chk("pre-reset sal_valid", bus.sal_valid, 1);
    @(negedge clk);
    bus.req0_valid = 0; bus.req1_valid = 0; bus.sal_ready = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset sal_valid", bus.sal_valid, 0);
    chk("async reset sal_dato", bus.sal_dato, 0);
    chk("async reset cuenta0", bus.cuenta0, 0);
    chk("async reset cuenta1", bus.cuenta1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1, 11, 1, 22, 1, r0, r1, sel);
    chk("post-reset grant req0_ready", r0, 1);
    chk("post-reset grant req1_ready", r1, 0);
    chk("post-reset seleccionador", sel, 0);
    chk("post-reset sal_dato", bus.sal_dato, 11);
    chk("post-reset cuenta0", bus.cuenta0, 1);

    // Saturation on the 4-bit counter instance
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus_s.req1_valid = 1; bus_s.req1_dato = 32'(i + 100); bus_s.sal_ready = 1;
      #1;
      chk("sat req1_ready", bus_s.req1_ready, 1);
      @(posedge clk);
      #1;
      chk($sformatf("sat cuenta1 after %0d", i + 1), bus_s.cuenta1, (i + 1 < 15) ? i + 1 : 15);
      chk("sat sal_dato", bus_s.sal_dato, 32'(i + 100));
    end
    chk("sat cuenta0", bus_s.cuenta0, 0);
    @(negedge clk);
    bus_s.req1_valid = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/arbitro_mux.md
Name: arbitro_mux

Overview:
- Two-requester round-robin arbiter and output register in front of the 32-bit 2:1 datapath multiplexer.
- Decides each cycle which source (Entrada1 or Entrada2 side) drives the shared 32-bit path and generates the mux select.
- Holds the selected word in an output register under a valid/ready handshake.
- Keeps saturating per-source transfer counters for debug and performance.

Parameters:
- ANCHO, 32, datapath width in bits.
- ANCHO_CNT, 16, width of each per-source transfer counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  source 0 has a word.
- req0_dato  input  ANCHO  source 0 word (Entrada1 side).
- req0_ready  output  1  source 0 word accepted this cycle.
- req1_valid  input  1  source 1 has a word.
- req1_dato  input  ANCHO  source 1 word (Entrada2 side).
- req1_ready  output  1  source 1 word accepted this cycle.
- seleccionador  output  1  mux select for the current grant: 0 = source 0, 1 = source 1.
- sal_valid  output  1  output register holds a word.
- sal_dato  output  ANCHO  registered output word.
- sal_fuente  output  1  source of the word in sal_dato.
- sal_ready  input  1  consumer accepts sal_dato this cycle.
- cuenta0  output  ANCHO_CNT  words accepted from source 0, saturating.
- cuenta1  output  ANCHO_CNT  words accepted from source 1, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous, any time):
  - sal_valid=0, sal_dato=0, sal_fuente=0, cuenta0=0, cuenta1=0, prioridad=0.
  - Any in-flight word is dropped.
  - Outputs are driven to reset values immediately, not at the next edge.
- State machine, 2 states, derived from sal_valid:
  - LIBRE (sal_valid=0).
  - OCUPADO (sal_valid=1).
- carga = !sal_valid | sal_ready (combinational). The output register can load this cycle.
- Grant (combinational):
  - Only one valid: grant goes to that source.
  - Both valid: grant goes to source prioridad.
  - Neither valid: grant = prioridad.
- seleccionador = grant at all times, including when idle.
- reqX_ready = carga & reqX_valid & (grant==X). At most one ready is high per cycle.
- Transfer from source X occurs when reqX_valid & reqX_ready. On that edge:
  - sal_dato <= selected word; sal_fuente <= X; sal_valid <= 1.
  - prioridad <= ~X.
  - cuentaX increments by 1, saturating at all-ones with no wrap.
- Output consumed (sal_valid & sal_ready) with no new transfer in the same cycle: sal_valid <= 0, sal_dato holds its value.
- Consume and new transfer in the same cycle: the register reloads. Throughput is 1 word/cycle with no bubble.
- sal_valid=1 & sal_ready=0 (stall):
  - sal_dato and sal_fuente are stable.
  - Both reqX_ready are 0.
  - prioridad is unchanged.
- Latency: a word accepted at edge N appears on sal_dato/sal_valid after edge N (1 cycle).
- Fairness: under continuous dual requests with sal_ready=1, grants strictly alternate 0,1,0,1... Neither source waits more than 1 transfer.
- Requesters must hold valid and dato until ready. The block does not sample dato without ready.
- prioridad changes only on a transfer. An idle cycle does not rotate it.

Test Plan:
- Reset mid-transfer: with sal_valid=1 and sal_dato=32'd7, assert rst_n=0 between edges -> sal_valid=0, sal_dato=0, cuenta0=cuenta1=0 immediately; after release, first dual request is granted to source 0.
- Single source: req0_valid=1, req0_dato=32'd1, sal_ready=1 -> req0_ready=1, seleccionador=0, next cycle sal_dato=1, sal_fuente=0, cuenta0=1.
- Round-robin: both valid (dato 32'd1 / 32'd2), sal_ready=1 for 4 cycles -> sal_dato sequence 1,2,1,2; sal_fuente 0,1,0,1; cuenta0=2, cuenta1=2.
- Backpressure: sal_valid=1 holding 32'd2, sal_ready=0 for 3 cycles with both requesting -> req0_ready=req1_ready=0, sal_dato stays 2, prioridad unchanged; raise sal_ready -> same-cycle reload, no bubble.
- Saturation: ANCHO_CNT=4, 17 transfers from source 1 -> cuenta1 stops at 15.
- Idle select: no valids after a source-0 transfer -> seleccionador=1 (prioridad), req0_ready=req1_ready=0, sal_valid drops after consume.
